// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - counter-cycle scheduler: latches plus/minus requests, grants one cell per memory cycle
// Optional feature macro: CNT_SCHED_CANCEL_EN (opposite-direction requests on one cell cancel each other)
module counter_sched #(
  parameter int NREQ   = 8,
  parameter int IDW    = 3,
  parameter int MAXRUN = 4
) (
  input  logic            SIM_CLK,
  input  logic            SIM_RST,
  input  logic            T12_STB,
  input  logic            GOJAM,
  input  logic            INHINC,
  input  logic [NREQ-1:0] REQ_P,
  input  logic [NREQ-1:0] REQ_M,
  output logic            CNT_GO,
  output logic [IDW-1:0]  CNT_ID,
  output logic            CNT_DIR,
  output logic [NREQ-1:0] PEND,
  output logic            OVR
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CNTR = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state_q;
  logic [NREQ-1:0] p_q, m_q, pend_q;
  logic [NREQ-1:0] p_g, m_g, p_d, m_d;
  logic            ovr_q, ovr_d;
  logic            go_q, dir_q;
  logic [IDW-1:0]  id_q;
  logic [3:0]      run_q, run_inc;

  logic            any_pend;
  logic [IDW-1:0]  sel;
  logic            run_full;
  logic            force_hold;
  logic            grant;

  // Priority encoder: lowest index wins, scanning from the top so the last hit sticks.
  always_comb begin
    any_pend = 1'b0;
    sel      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (p_q[i] || m_q[i]) begin
        any_pend = 1'b1;
        sel      = IDW'(i);
      end
    end
  end

  assign run_full   = (run_q == 4'(MAXRUN));
  assign run_inc    = run_full ? run_q : run_q + 4'd1;
  assign force_hold = T12_STB && !GOJAM && (state_q == S_CNTR) && run_full;
  assign grant      = T12_STB && !GOJAM && !force_hold && !INHINC && any_pend;

  // Grant consumes its bit first; this cycle's requests are then merged on top of that.
  always_comb begin
    p_g = p_q;
    m_g = m_q;
    if (grant) begin
      if (p_q[sel]) p_g[sel] = 1'b0;
      else          m_g[sel] = 1'b0;
    end

    p_d   = p_g;
    m_d   = m_g;
    ovr_d = ovr_q;
    for (int i = 0; i < NREQ; i++) begin
`ifdef CNT_SCHED_CANCEL_EN
      if (REQ_P[i] && !REQ_M[i]) begin
        if (m_g[i])      m_d[i] = 1'b0;
        else if (p_g[i]) ovr_d  = 1'b1;
        else             p_d[i] = 1'b1;
      end else if (REQ_M[i] && !REQ_P[i]) begin
        if (p_g[i])      p_d[i] = 1'b0;
        else if (m_g[i]) ovr_d  = 1'b1;
        else             m_d[i] = 1'b1;
      end
`else
      if (REQ_P[i]) begin
        if (p_g[i]) ovr_d  = 1'b1;
        else        p_d[i] = 1'b1;
      end
      if (REQ_M[i]) begin
        if (m_g[i]) ovr_d  = 1'b1;
        else        m_d[i] = 1'b1;
      end
`endif
    end

    if (GOJAM) begin
      p_d   = '0;
      m_d   = '0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      m_q     <= '0;
      pend_q  <= '0;
      ovr_q   <= 1'b0;
      go_q    <= 1'b0;
      id_q    <= '0;
      dir_q   <= 1'b0;
      run_q   <= 4'd0;
    end else begin
      p_q    <= p_d;
      m_q    <= m_d;
      pend_q <= p_d | m_d;
      ovr_q  <= ovr_d;
      if (GOJAM) begin
        state_q <= S_IDLE;
        go_q    <= 1'b0;
        run_q   <= 4'd0;
      end else if (T12_STB) begin
        if (force_hold) begin
          state_q <= S_HOLD;
          go_q    <= 1'b0;
          run_q   <= 4'd0;
        end else if (grant) begin
          state_q <= S_CNTR;
          go_q    <= 1'b1;
          id_q    <= sel;
          dir_q   <= p_q[sel];
          run_q   <= run_inc;
        end else begin
          state_q <= S_IDLE;
          go_q    <= 1'b0;
          run_q   <= 4'd0;
        end
      end
    end
  end

  assign CNT_GO  = go_q;
  assign CNT_ID  = id_q;
  assign CNT_DIR = dir_q;
  assign PEND    = pend_q;
  assign OVR     = ovr_q;

endmodule
